multdiv_scheduler: RTL and testbench
====================================

# multdiv_scheduler

Shares the processor's single multi-cycle `multdiv` unit between two requesters: port 0 is the pipeline execute stage, port 1 is the game-logic coprocessor. Each port gets a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin and latches operands so they stay stable for the whole operation. It issues a one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, waits for `resultRDY` (with a timeout), and returns result and exception to the winning port.

## Interface
- `TIMEOUT`, default 40: maximum BUSY cycles before the operation is aborted.
- `TAG_W`, default 4: width of the requester tag echoed back with the response.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port request accepted this cycle.
- `req_is_div[1:0]` in 2: per port, 1 = divide, 0 = multiply.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands for port 0 and port 1.
- `req_tag0`, `req_tag1` in TAG_W each: requester tags.
- `resp_valid[1:0]` out 2: per-port response valid.
- `resp_ready[1:0]` in 2: per-port response consumed.
- `resp_result` out 32: shared result bus, valid only where `resp_valid` is set.
- `resp_exception` out 1: overflow, divide-by-zero or timeout.
- `resp_tag` out TAG_W: tag of the completed request.
- `md_operandA`, `md_operandB` out 32: to the multdiv unit.
- `md_ctrl_MULT`, `md_ctrl_DIV` out 1: start pulses to the multdiv unit.
- `md_result` in 32, `md_exception` in 1, `md_resultRDY` in 1: from the multdiv unit.

## Operation
- States: IDLE, START, BUSY, RESP.
- **IDLE**
  - If any `req_valid` is set, grant one port and raise its `req_ready` for that cycle only (a combinational function of IDLE and the arbiter).
  - Latch operands, op and tag, then go to START.
  - Arbitration is round-robin:
    - A 1-bit `last_grant` register is reset to 1, so port 0 wins the first tie.
    - With both ports valid, grant `~last_grant`; with one port valid, grant it.
    - `last_grant` updates on every grant.
- **START**, exactly one cycle
  - Assert exactly one of `md_ctrl_MULT` or `md_ctrl_DIV`.
  - Clear the timeout counter, then go to BUSY.
- **BUSY**
  - `md_ctrl_*` are 0. `md_resultRDY` is sampled only in this state.
  - On `md_resultRDY`: capture `md_result` and `md_exception` into the response registers, then go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without RDY, load result = 0 and exception = 1, then go to RESP.
  - If RDY and timeout occur in the same cycle, RDY wins.
- **RESP**
  - Hold `resp_valid[granted]` high, with result, exception and tag stable, until `resp_ready[granted]` is high.
  - Then return to IDLE. No new grant happens in that same cycle.
  - `resp_valid` of the non-granted port stays 0.
- `md_operandA` and `md_operandB` are driven from the latched registers in every state, so they are stable from START through RESP.
- Requests are never dropped: a port holding `req_valid` waits in IDLE until it is granted.
- At most one operation is in flight.
- Asynchronous reset mid-operation:
  - Forces IDLE and clears all pulses and valids.
  - The in-flight result is discarded. The multdiv unit's internal state is then don't-care until the next start pulse.

## Timing
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `md_ctrl_MULT` = `md_ctrl_DIV` = 0.
  - `resp_result` = 0, `resp_exception` = 0, `resp_tag` = 0.
  - `md_operandA` = `md_operandB` = 0, `last_grant` = 1, state = IDLE.
- Latency, counted from the accept cycle (cycle 0) with RDY seen on the k-th BUSY cycle (k ≥ 1):
  - START at cycle 1, BUSY begins at cycle 2.
  - `resp_valid` rises at cycle 2+k.
- Minimum spacing between accepts is 4 cycles: accept, START, BUSY (k = 1), then RESP with immediate `resp_ready`, giving the next accept at cycle 4.
- Timeout path: `resp_valid` rises TIMEOUT cycles after BUSY entry.
- `req_ready` never asserts outside IDLE.
- At most one bit of `resp_valid` is set at any time.

## Structure
- Shared package `multdiv_pkg`:
  - State encoding: IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, RESP = 2'd3.
  - Op encoding: OP_MUL = 1'b0, OP_DIV = 1'b1.
  - Default TIMEOUT constant.
- Sub-module `rr_arbiter2`: 2-input round-robin grant with a `last_grant` register and an advance enable, kept separately testable.
- The scheduler instantiates `rr_arbiter2` and a counter sized to clog2(TIMEOUT). The multdiv unit itself is instantiated by the parent, not inside this block.

## Test plan
- **Single multiply:** port 0 only, a = 7, b = 6, mul; stub RDY after 3 BUSY cycles with result 42 → one `md_ctrl_MULT` pulse, `resp_valid[0]` at cycle 5, `resp_result` = 42, exception = 0, tag echoed.
- **Contention:** both ports valid continuously from reset → grants go 0, 1, 0, 1; each port holds `req_valid` until its `req_ready`.
- **Divide by zero:** port 1 div, a = 10, b = 0; stub returns exception = 1 → `resp_exception` = 1 on port 1 only.
- **Timeout:** TIMEOUT = 8, stub never asserts RDY → after 8 BUSY cycles, result = 0, exception = 1.
- **Response backpressure:** `resp_ready` low for 5 cycles → response outputs stable and no new `req_ready` until the handshake completes.
- **Reset mid-operation:** `reset` low during BUSY → next cycle all outputs at reset values; a fresh request then completes normally with port 0 winning a tie.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv scheduler.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  localparam int unsigned TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; last_grant resets to 1 so port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant;

  always_comb begin
    grant_valid = |req;
    grant_idx   = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/multdiv_scheduler.sv
// Shares one multi-cycle multdiv unit between two valid/ready requesters,
// round-robin, one operation in flight, with a BUSY timeout.
module multdiv_scheduler
  import multdiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_is_div,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_exception,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               gnt_q;
  op_t                op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        opa_q, opb_q, res_q;
  logic               exc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               grant_valid, grant_idx, accept, timeout_hit;

  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (req_valid),
    .advance     (accept),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    accept       = (state_q == IDLE) && grant_valid;
    timeout_hit  = (cnt_q == CNT_LAST);
    state_d      = state_q;
    req_ready    = '0;
    resp_valid   = '0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d              = START;
          req_ready[grant_idx] = 1'b1;
        end
      end
      START: begin
        state_d      = BUSY;
        md_ctrl_MULT = (op_q == OP_MUL);
        md_ctrl_DIV  = (op_q == OP_DIV);
      end
      // RDY is checked ahead of the counter so it wins a same-cycle timeout
      BUSY: begin
        if (md_resultRDY || timeout_hit) state_d = RESP;
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q <= 1'b0;
      op_q  <= OP_MUL;
      tag_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q <= grant_idx;
            op_q  <= op_t'(req_is_div[grant_idx]);
            tag_q <= grant_idx ? req_tag1 : req_tag0;
            opa_q <= grant_idx ? req_a1 : req_a0;
            opb_q <= grant_idx ? req_b1 : req_b0;
          end
        end
        START: cnt_q <= '0;
        BUSY: begin
          if (md_resultRDY) begin
            res_q <= md_result;
            exc_q <= md_exception;
          end else if (timeout_hit) begin
            res_q <= '0;
            exc_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_result    = res_q;
  assign resp_exception = exc_q;
  assign resp_tag       = tag_q;
  assign md_operandA    = opa_q;
  assign md_operandB    = opb_q;

endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler with a behavioural multdiv stub.
module tb_multdiv_scheduler;

  localparam int unsigned TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_is_div = '0;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [3:0]  req_tag0 = '0, req_tag1 = '0;
  logic [1:0]  resp_valid, resp_ready = '0;
  logic [31:0] resp_result;
  logic        resp_exception;
  logic [3:0]  resp_tag;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;

  always #5 clock = ~clock;

  multdiv_scheduler #(.TIMEOUT(TO), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_exception(resp_exception), .resp_tag(resp_tag),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY)
  );

  // Stub: RDY on the stub_k-th cycle after a start pulse (stub_k = 0 means never)
  int unsigned stub_k = 0;
  logic [31:0] stub_res = '0;
  logic        stub_exc = 1'b0;
  logic        stub_active = 1'b0;
  int unsigned stub_cnt = 0;
  int unsigned pulses = 0;

  always @(posedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      pulses      <= pulses + 1;
    end else if (stub_active) begin
      if (md_resultRDY) stub_active <= 1'b0;
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign md_resultRDY = stub_active && (stub_k != 0) && (stub_cnt == stub_k);
  assign md_result    = md_resultRDY ? stub_res : 32'hBAD0_BAD0;
  assign md_exception = md_resultRDY ? stub_exc : 1'b1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string sfx);
    chk({"rst_req_ready_", sfx}, 64'(req_ready), 64'd0);
    chk({"rst_resp_valid_", sfx}, 64'(resp_valid), 64'd0);
    chk({"rst_ctrl_", sfx}, 64'({md_ctrl_MULT, md_ctrl_DIV}), 64'd0);
    chk({"rst_resp_", sfx}, 64'({resp_result, resp_exception, resp_tag}), 64'd0);
    chk({"rst_operands_", sfx}, {md_operandA, md_operandB}, 64'd0);
  endtask

  // n counts from the START cycle (n = 1); -1 when the bound expires
  task automatic wait_resp(output int n);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      n++;
      if (resp_valid != 2'b00) return;
    end
    n = -1;
  endtask

  typedef struct {
    int unsigned port;
    logic        is_div;
    logic [31:0] a, b;
    logic [3:0]  tag;
    int unsigned k;
    logic [31:0] stub_res;
    logic        stub_exc;
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int unsigned p0;
    logic [1:0] oh;
    string s;
    s  = $sformatf("v%0d_", idx);
    oh = 2'(1 << v.port);
    @(negedge clock);
    stub_k = v.k; stub_res = v.stub_res; stub_exc = v.stub_exc;
    p0 = pulses;
    if (v.port == 0) begin req_a0 = v.a; req_b0 = v.b; req_tag0 = v.tag; end
    else             begin req_a1 = v.a; req_b1 = v.b; req_tag1 = v.tag; end
    req_is_div[v.port] = v.is_div;
    req_valid = oh;
    #1;
    chk({s, "accept"}, 64'(req_ready), 64'(oh));
    @(negedge clock);
    req_valid = '0;
    #1;
    chk({s, "start_pulse"}, 64'({md_ctrl_MULT, md_ctrl_DIV}), v.is_div ? 64'd1 : 64'd2);
    chk({s, "operands"}, {md_operandA, md_operandB}, {v.a, v.b});
    wait_resp(n);
    chk({s, "latency"}, 64'(n), 64'(v.exp_lat));
    chk({s, "resp_valid"}, 64'(resp_valid), 64'(oh));
    chk({s, "result"}, 64'(resp_result), 64'(v.exp_res));
    chk({s, "exception"}, 64'(resp_exception), 64'(v.exp_exc));
    chk({s, "tag"}, 64'(resp_tag), 64'(v.tag));
    resp_ready = oh;
    @(negedge clock);
    resp_ready = '0;
    #1;
    chk({s, "released"}, 64'(resp_valid), 64'd0);
    chk({s, "pulse_count"}, 64'(pulses - p0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g, last, n;
    vecs[0] = '{0, 1'b0, 32'd7,          32'd6, 4'h5, 3, 32'd42,          1'b0, 32'd42,          1'b0, 5};
    vecs[1] = '{1, 1'b1, 32'd10,         32'd0, 4'h9, 2, 32'd0,           1'b1, 32'd0,           1'b1, 4};
    vecs[2] = '{0, 1'b1, 32'd100,        32'd7, 4'h3, 1, 32'd14,          1'b0, 32'd14,          1'b0, 3};
    vecs[3] = '{1, 1'b0, 32'hFFFF_FFFF,  32'd2, 4'hF, 8, 32'hFFFF_FFFE,   1'b0, 32'hFFFF_FFFE,   1'b0, 10};
    vecs[4] = '{0, 1'b0, 32'd123,        32'd4, 4'h2, 0, 32'hDEAD_BEEF,   1'b0, 32'd0,           1'b1, 10};
    vecs[5] = '{1, 1'b0, 32'h1234,       32'd9, 4'h0, 7, 32'h1234_5678,   1'b0, 32'h1234_5678,   1'b0, 9};

    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("init");
    reset = 1'b1;

    // Contention from reset: grants alternate 0,1,0,1 at minimum spacing
    @(negedge clock);
    stub_k = 1; stub_res = 32'h11; stub_exc = 1'b0;
    req_a0 = 32'd1; req_b0 = 32'd2; req_a1 = 32'd3; req_b1 = 32'd4;
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    #1;
    g = 0; last = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      if (req_ready != 2'b00) begin
        chk("contention_grant", 64'(req_ready), (g % 2 == 0) ? 64'd1 : 64'd2);
        if (g > 0) chk("contention_spacing", 64'(c - last), 64'd4);
        last = c;
        g++;
      end
      if (g < 4) begin @(negedge clock); #1; end
    end
    chk("contention_count", 64'(g), 64'd4);
    @(negedge clock);
    req_valid = '0;
    repeat (6) @(negedge clock);
    resp_ready = '0;
    chk("contention_pulses", 64'(pulses), 64'd4);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Response backpressure with a competing request pending
    @(negedge clock);
    stub_k = 1; stub_res = 32'h55; stub_exc = 1'b0;
    req_a0 = 32'd5; req_b0 = 32'd11; req_tag0 = 4'h6; req_is_div = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("bp_accept", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = '0;
    wait_resp(n);
    chk("bp_latency", 64'(n), 64'd3);
    req_a1 = 32'd8; req_b1 = 32'd9; req_tag1 = 4'hC;
    req_valid = 2'b10;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {23'd0, resp_valid, req_ready, resp_result, resp_exception, resp_tag},
          {23'd0, 2'b01, 2'b00, 32'h55, 1'b0, 4'h6});
      @(negedge clock); #1;
    end
    stub_res = 32'h66;
    resp_ready = 2'b01;
    #1;
    chk("bp_handshake_cycle", 64'(req_ready), 64'd0);
    @(negedge clock);
    resp_ready = '0;
    #1;
    chk("bp_next_accept", 64'({resp_valid, req_ready}), 64'b0010);
    @(negedge clock);
    req_valid = '0;
    wait_resp(n);
    chk("bp_second_resp", {24'd0, resp_valid, resp_result, resp_tag, resp_exception},
        {24'd0, 2'b10, 32'h66, 4'hC, 1'b0});
    resp_ready = 2'b10;
    @(negedge clock);
    resp_ready = '0;

    // Asynchronous reset during BUSY, after port 0 was the last grant
    @(negedge clock);
    stub_k = 0;
    req_a0 = 32'd3; req_b0 = 32'd4; req_tag0 = 4'hA;
    req_valid = 2'b01;
    #1;
    chk("rm_accept", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clock);
    reset = 1'b1;
    stub_k = 2; stub_res = 32'd77; stub_exc = 1'b0;
    req_a0 = 32'd7; req_b0 = 32'd11; req_tag0 = 4'h4;
    req_valid = 2'b11;
    #1;
    chk("rm_tie_grant", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = '0;
    #1;
    chk("rm_start", 64'({md_ctrl_MULT, md_ctrl_DIV}), 64'd2);
    wait_resp(n);
    chk("rm_latency", 64'(n), 64'd4);
    chk("rm_resp", {24'd0, resp_valid, resp_result, resp_tag, resp_exception},
        {24'd0, 2'b01, 32'd77, 4'h4, 1'b0});
    resp_ready = 2'b01;
    @(negedge clock);
    resp_ready = '0;
    #1;
    chk("rm_released", 64'(resp_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
